// File: rtl/wb_chan_fanout_if.sv
// Bus bundle for the Wishbone channel fan-out: one host-side port plus the
// per-channel request lines and per-channel response/read-data returns.
//
// Handshake: a requester holds cyc&stb (and we/adr/dat/sel stable) until the
// responder pulses exactly one of ack/err/rty for a single cycle; the request
// is complete on that cycle and the requester drops stb (and cyc) afterwards.
// The same rule applies independently on every downstream channel.
interface wb_chan_fanout_if #(
  parameter int NCHAN          = 8,
  parameter int ADR_WIDTH      = 22,
  parameter int DAT_WIDTH      = 32,
  parameter int LOCAL_ADR_BITS = 8
);
  // host side
  logic                   wb_cyc_i;
  logic                   wb_stb_i;
  logic                   wb_we_i;
  logic [ADR_WIDTH-1:0]   wb_adr_i;
  logic [DAT_WIDTH-1:0]   wb_dat_i;
  logic [DAT_WIDTH/8-1:0] wb_sel_i;
  logic                   wb_ack_o;
  logic                   wb_err_o;
  logic                   wb_rty_o;
  logic [DAT_WIDTH-1:0]   wb_dat_o;

  // channel side
  logic [NCHAN-1:0]                wbm_cyc_o;
  logic [NCHAN-1:0]                wbm_stb_o;
  logic                            wbm_we_o;
  logic [LOCAL_ADR_BITS-1:0]       wbm_adr_o;
  logic [DAT_WIDTH-1:0]            wbm_dat_o;
  logic [DAT_WIDTH/8-1:0]          wbm_sel_o;
  logic [NCHAN-1:0]                wbm_ack_i;
  logic [NCHAN-1:0]                wbm_err_i;
  logic [NCHAN-1:0]                wbm_rty_i;
  logic [NCHAN-1:0][DAT_WIDTH-1:0] wbm_dat_i;

  // fan-out block view: slave to the host, master to the channels
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_ack_i, wbm_err_i, wbm_rty_i, wbm_dat_i
  );

  // host/channel-model view
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_ack_i, wbm_err_i, wbm_rty_i, wbm_dat_i
  );
endinterface

// File: rtl/wb_chan_fanout.sv
// Wishbone classic 1-to-NCHAN channel fan-out. Decodes a channel index from
// the host address, forwards a registered request to one channel (or to all
// channels on a broadcast write), collects the responses and returns a single
// ack/err/rty pulse. Adds decode errors, a per-transaction timeout with a
// saturating timeout counter, and host-abort handling. All outputs registered.
module wb_chan_fanout #(
  parameter int NCHAN          = 8,
  parameter int ADR_WIDTH      = 22,
  parameter int DAT_WIDTH      = 32,
  parameter int LOCAL_ADR_BITS = 8,
  parameter int CHAN_LSB       = 10,
  parameter int CHAN_BITS      = 3,
  parameter int BCAST_BIT      = 13,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_chan_fanout_if.slave     bus,
  output logic [15:0]         timeout_count_o,
  output logic [1:0]          state_o
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NCHAN-1:0]     mask_q;     // channels targeted by this transaction
  logic [NCHAN-1:0]     done_q;     // channels that have responded
  logic [NCHAN-1:0]     cyc_q;      // channels still being driven
  logic                 err_f_q;
  logic                 rty_f_q;
  logic [TW-1:0]        timer_q;
  logic [DAT_WIDTH-1:0] rdat_q;

  logic                 ack_q, err_q, rty_q;
  logic [DAT_WIDTH-1:0] dat_q;
  logic                 we_q;
  logic [LOCAL_ADR_BITS-1:0] adr_q;
  logic [DAT_WIDTH-1:0]      wdat_q;
  logic [DAT_WIDTH/8-1:0]    sel_q;
  logic [15:0]               tcount_q;

  // request decode
  logic                 req;
  logic [CHAN_BITS-1:0] idx;
  logic                 bc;
  logic                 decode_err;
  logic [NCHAN-1:0]     req_mask;

  // response collection
  logic [NCHAN-1:0]     hit;
  logic [NCHAN-1:0]     done_d;
  logic                 err_d;
  logic                 rty_d;
  logic                 all_done;
  logic [DAT_WIDTH-1:0] rdat_d;

  // FSM actions
  logic accept;
  logic drop_all;
  logic timeout_hit;
  logic go_ack, go_err, go_rty;

  // Address bits outside the index/local/broadcast fields are ignored.
  logic unused_adr;
  assign unused_adr = ^bus.wb_adr_i;

  assign req        = bus.wb_cyc_i & bus.wb_stb_i;
  assign idx        = bus.wb_adr_i[CHAN_LSB +: CHAN_BITS];
  assign bc         = bus.wb_adr_i[BCAST_BIT];
  assign decode_err = (!bus.wb_we_i && bc) ||
                      (!bc && ({1'b0, idx} >= (CHAN_BITS+1)'(NCHAN)));
  assign req_mask   = bc ? {NCHAN{1'b1}} : (NCHAN'(1) << idx);

  // Only channels still being driven may contribute a response.
  assign hit      = (bus.wbm_ack_i | bus.wbm_err_i | bus.wbm_rty_i) & cyc_q;
  assign done_d   = done_q | hit;
  assign err_d    = err_f_q | (|(bus.wbm_err_i & cyc_q));
  assign rty_d    = rty_f_q | (|(bus.wbm_rty_i & cyc_q));
  assign all_done = (done_d == mask_q);

  // Capture unicast read data on a clean ack (ack together with err is an err).
  always_comb begin
    rdat_d = rdat_q;
    for (int c = 0; c < NCHAN; c++) begin
      if (cyc_q[c] && bus.wbm_ack_i[c] && !bus.wbm_err_i[c]) begin
        rdat_d = bus.wbm_dat_i[c];
      end
    end
  end

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state and per-cycle actions; abort beats completion beats timeout
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    drop_all    = 1'b0;
    timeout_hit = 1'b0;
    go_ack      = 1'b0;
    go_err      = 1'b0;
    go_rty      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (decode_err) begin
            state_d = RESP;
            go_err  = 1'b1;
          end else begin
            state_d = WAIT;
            accept  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!bus.wb_cyc_i) begin
          state_d  = IDLE;
          drop_all = 1'b1;
        end else if (all_done) begin
          state_d = RESP;
          if (err_d)      go_err = 1'b1;
          else if (rty_d) go_rty = 1'b1;
          else            go_ack = 1'b1;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESP;
          go_err      = 1'b1;
          drop_all    = 1'b1;
          timeout_hit = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: request latch, response collection, host response and counter
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mask_q   <= '0;
      done_q   <= '0;
      cyc_q    <= '0;
      err_f_q  <= 1'b0;
      rty_f_q  <= 1'b0;
      timer_q  <= '0;
      rdat_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rty_q    <= 1'b0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wdat_q   <= '0;
      sel_q    <= '0;
      tcount_q <= '0;
    end else begin
      ack_q <= go_ack;
      err_q <= go_err;
      rty_q <= go_rty;
      dat_q <= (go_ack && !we_q) ? rdat_d : '0;
      if (accept) begin
        we_q    <= bus.wb_we_i;
        adr_q   <= bus.wb_adr_i[LOCAL_ADR_BITS-1:0];
        wdat_q  <= bus.wb_dat_i;
        sel_q   <= bus.wb_sel_i;
        mask_q  <= req_mask;
        cyc_q   <= req_mask;
        done_q  <= '0;
        err_f_q <= 1'b0;
        rty_f_q <= 1'b0;
        timer_q <= '0;
        rdat_q  <= '0;
      end else if (state_q == WAIT) begin
        done_q  <= done_d;
        err_f_q <= err_d;
        rty_f_q <= rty_d;
        rdat_q  <= rdat_d;
        timer_q <= timer_q + TW'(1);
        cyc_q   <= drop_all ? '0 : (mask_q & ~done_d);
      end
      if (timeout_hit && (tcount_q != 16'hFFFF)) begin
        tcount_q <= tcount_q + 16'd1;
      end
    end
  end

  assign bus.wb_ack_o  = ack_q;
  assign bus.wb_err_o  = err_q;
  assign bus.wb_rty_o  = rty_q;
  assign bus.wb_dat_o  = dat_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = wdat_q;
  assign bus.wbm_sel_o = sel_q;

  assign timeout_count_o = tcount_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_wb_chan_fanout.sv
// Bench for wb_chan_fanout: directed host requests against a programmable
// per-channel responder model; host responses are checked by a scoreboard
// monitor, channel-side behaviour by direct checks in the stimulus.
module tb_wb_chan_fanout;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_chan_fanout_if #(.NCHAN(8)) if8 ();
  wb_chan_fanout_if #(.NCHAN(6)) if6 ();
  logic [15:0] tcnt8, tcnt6;
  logic [1:0]  st8, st6;

  wb_chan_fanout #(.NCHAN(8), .TIMEOUT_CYCLES(16)) dut8 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(if8),
    .timeout_count_o(tcnt8), .state_o(st8)
  );

  wb_chan_fanout #(.NCHAN(6)) dut6 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(if6),
    .timeout_count_o(tcnt6), .state_o(st6)
  );

  int total = 0;
  int bad   = 0;
  int stale = 0;

  // channel responder model: kind 0=ack 1=err 2=rty 3=silent 4=ack+err
  int          delay [8];
  int          kind  [8];
  logic [31:0] rdata [8];
  int          cnt   [8];

  always @(posedge clk) begin
    for (int c = 0; c < 8; c++) begin
      if (rst || !if8.wbm_cyc_o[c]) cnt[c] <= 0;
      else                          cnt[c] <= cnt[c] + 1;
    end
  end

  always_comb begin
    for (int c = 0; c < 8; c++) begin
      if8.wbm_ack_i[c] = if8.wbm_cyc_o[c] && (cnt[c] == delay[c]) && (kind[c] == 0 || kind[c] == 4);
      if8.wbm_err_i[c] = if8.wbm_cyc_o[c] && (cnt[c] == delay[c]) && (kind[c] == 1 || kind[c] == 4);
      if8.wbm_rty_i[c] = if8.wbm_cyc_o[c] && (cnt[c] == delay[c]) && (kind[c] == 2);
      if8.wbm_dat_i[c] = rdata[c];
    end
  end

  assign if6.wbm_ack_i = '0;
  assign if6.wbm_err_i = '0;
  assign if6.wbm_rty_i = '0;
  assign if6.wbm_dat_i = '0;

  // A channel must drop cyc the cycle after it responds; stb must follow cyc.
  always @(negedge clk) begin
    for (int c = 0; c < 8; c++) begin
      if (if8.wbm_cyc_o[c] && kind[c] != 3 && cnt[c] > delay[c]) stale++;
    end
    if (if8.wbm_stb_o !== if8.wbm_cyc_o) stale++;
  end

  // scoreboard: {ack, err, rty, dat}
  logic [34:0] exp_q[$];

  always @(negedge clk) begin
    logic [34:0] exp_v;
    logic [34:0] act_v;
    if (!rst && (if8.wb_ack_o || if8.wb_err_o || if8.wb_rty_o)) begin
      act_v = {if8.wb_ack_o, if8.wb_err_o, if8.wb_rty_o, if8.wb_dat_o};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp act=%h exp=none", act_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          bad++;
          $display("FAIL host_resp act=%h exp=%h", act_v, exp_v);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // driver: issue one request, wait for its response, record first-cycle view
  logic [7:0]  obs_cyc, obs_adr;
  logic [31:0] obs_dat;
  logic        obs_we;

  task automatic do_req(input logic we, input logic [21:0] adr, input logic [31:0] dat,
                        output int cycles);
    @(posedge clk); #1;
    if8.wb_cyc_i = 1'b1; if8.wb_stb_i = 1'b1; if8.wb_we_i = we;
    if8.wb_adr_i = adr;  if8.wb_dat_i = dat;  if8.wb_sel_i = 4'hF;
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1) begin
        obs_cyc = if8.wbm_cyc_o; obs_adr = if8.wbm_adr_o;
        obs_dat = if8.wbm_dat_o; obs_we  = if8.wbm_we_o;
      end
      if (if8.wb_ack_o || if8.wb_err_o || if8.wb_rty_o) break;
    end
    if (cycles >= 100) begin
      total++; bad++;
      $display("FAIL resp_timeout act=none exp=response adr=%h", adr);
    end
    if8.wb_cyc_i = 1'b0; if8.wb_stb_i = 1'b0;
  endtask

  task automatic set_ch(input int c, input int k, input int d, input logic [31:0] rd);
    kind[c] = k; delay[c] = d; rdata[c] = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc_n;
    for (int c = 0; c < 8; c++) set_ch(c, 3, 1, 32'h0);
    if8.wb_cyc_i = 0; if8.wb_stb_i = 0; if8.wb_we_i = 0;
    if8.wb_adr_i = '0; if8.wb_dat_i = '0; if8.wb_sel_i = '0;
    if6.wb_cyc_i = 0; if6.wb_stb_i = 0; if6.wb_we_i = 0;
    if6.wb_adr_i = '0; if6.wb_dat_i = '0; if6.wb_sel_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", if8.wbm_cyc_o, 0);
    chk("rst_resp", {if8.wb_ack_o, if8.wb_err_o, if8.wb_rty_o, if8.wb_dat_o}, 0);
    chk("rst_tcnt", tcnt8, 0);
    chk("rst_state", st8, 0);
    rst = 1'b0;

    // unicast read ch5, ack after 2 cycles
    set_ch(5, 0, 2, 32'hDEADBEEF);
    exp_q.push_back({3'b100, 32'hDEADBEEF});
    do_req(1'b0, 22'h1404, 32'h0, cyc_n);
    chk("rd5_cyc", obs_cyc, 8'h20);
    chk("rd5_adr", obs_adr, 8'h04);
    chk("rd5_lat", cyc_n, 4);
    set_ch(5, 3, 1, 32'h0);

    // unicast read top channel, 1-cycle ack latency
    set_ch(7, 0, 1, 32'h77770007);
    exp_q.push_back({3'b100, 32'h77770007});
    do_req(1'b0, 22'h1C08, 32'h0, cyc_n);
    chk("rd7_cyc", obs_cyc, 8'h80);
    chk("rd7_lat", cyc_n, 3);

    // unicast write ch0: read data ignored, dat_o must be 0
    set_ch(0, 0, 1, 32'h55AA55AA);
    exp_q.push_back({3'b100, 32'h0});
    do_req(1'b1, 22'h0033, 32'hA5A5_0001, cyc_n);
    chk("wr0_dat", obs_dat, 32'hA5A50001);
    chk("wr0_we", obs_we, 1);
    chk("wr0_adr", obs_adr, 8'h33);

    // retry from ch1
    set_ch(1, 2, 1, 32'h0);
    exp_q.push_back({3'b001, 32'h0});
    do_req(1'b1, 22'h0400, 32'h1, cyc_n);
    chk("rty1_lat", cyc_n, 3);

    // simultaneous ack+err on ch6 counts as err
    set_ch(6, 4, 1, 32'h66666666);
    exp_q.push_back({3'b010, 32'h0});
    do_req(1'b0, 22'h1800, 32'h0, cyc_n);

    // broadcast write, staggered acks 1..8
    for (int c = 0; c < 8; c++) set_ch(c, 0, c + 1, 32'h0);
    exp_q.push_back({3'b100, 32'h0});
    do_req(1'b1, 22'h2010, 32'h1234, cyc_n);
    chk("bc_cyc", obs_cyc, 8'hFF);
    chk("bc_adr", obs_adr, 8'h10);
    chk("bc_dat", obs_dat, 32'h1234);
    chk("bc_lat", cyc_n, 10);

    // broadcast write with ch3 err
    set_ch(3, 1, 4, 32'h0);
    exp_q.push_back({3'b010, 32'h0});
    do_req(1'b1, 22'h2010, 32'h5678, cyc_n);
    chk("bcerr_lat", cyc_n, 10);

    // broadcast read is a decode error
    exp_q.push_back({3'b010, 32'h0});
    do_req(1'b0, 22'h2010, 32'h0, cyc_n);
    chk("bcrd_cyc", obs_cyc, 8'h00);
    chk("bcrd_lat", cyc_n, 1);

    // timeout on silent ch2, then a normal access to ch2
    for (int c = 0; c < 8; c++) set_ch(c, 3, 1, 32'h0);
    exp_q.push_back({3'b010, 32'h0});
    do_req(1'b0, 22'h0800, 32'h0, cyc_n);
    chk("to_lat", cyc_n, 17);
    chk("to_cyc_drop", if8.wbm_cyc_o, 8'h00);
    chk("to_count", tcnt8, 1);
    set_ch(2, 0, 1, 32'hCAFEF00D);
    exp_q.push_back({3'b100, 32'hCAFEF00D});
    do_req(1'b0, 22'h0804, 32'h0, cyc_n);
    chk("to_next_lat", cyc_n, 3);
    set_ch(2, 3, 1, 32'h0);

    // host abort during WAIT on silent ch4: no response
    @(posedge clk); #1;
    if8.wb_cyc_i = 1; if8.wb_stb_i = 1; if8.wb_we_i = 0; if8.wb_adr_i = 22'h1000;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_active", if8.wbm_cyc_o, 8'h10);
    if8.wb_cyc_i = 0; if8.wb_stb_i = 0;
    @(posedge clk); #1;
    chk("abort_cyc", if8.wbm_cyc_o, 8'h00);
    chk("abort_state", st8, 0);
    repeat (4) @(posedge clk);

    // reset during WAIT: everything cleared, timeout count too
    @(posedge clk); #1;
    if8.wb_cyc_i = 1; if8.wb_stb_i = 1; if8.wb_we_i = 1;
    if8.wb_adr_i = 22'h1855; if8.wb_dat_i = 32'hFFFF0000;
    repeat (3) begin @(posedge clk); #1; end
    chk("rstw_active", if8.wbm_cyc_o, 8'h40);
    rst = 1; if8.wb_cyc_i = 0; if8.wb_stb_i = 0;
    @(posedge clk); #1;
    chk("rstw_cyc", if8.wbm_cyc_o, 0);
    chk("rstw_bus", {if8.wbm_we_o, if8.wbm_adr_o, if8.wbm_dat_o, if8.wbm_sel_o}, 0);
    chk("rstw_tcnt", tcnt8, 0);
    chk("rstw_state", st8, 0);
    rst = 0;
    repeat (2) @(posedge clk);

    // NCHAN=6: index 7 is out of range
    @(posedge clk); #1;
    if6.wb_cyc_i = 1; if6.wb_stb_i = 1; if6.wb_we_i = 0; if6.wb_adr_i = 22'h1C00;
    @(posedge clk); #1;
    chk("n6_err", {if6.wb_ack_o, if6.wb_err_o, if6.wb_rty_o}, 3'b010);
    chk("n6_cyc", if6.wbm_cyc_o, 0);
    if6.wb_cyc_i = 0; if6.wb_stb_i = 0;
    @(posedge clk); #1;
    chk("n6_pulse", if6.wb_err_o, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", exp_q.size(), 0);
    chk("chan_drop", stale, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
